// File: rtl/m_axi_srl_fifo.sv
// SRL-style FIFO for the m_axi data/address channels: a shift-in array read through
// a pointer, followed by a registered output stage with valid/ready on both sides.
module m_axi_srl_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 63,
    parameter int AF_MARGIN  = 4,
    parameter int AE_MARGIN  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_LEVEL   = (ADDR_WIDTH+1)'(DEPTH - AF_MARGIN);
    localparam logic [ADDR_WIDTH:0]   AE_LEVEL   = (ADDR_WIDTH+1)'(AE_MARGIN);
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE    = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-2];
    logic [ADDR_WIDTH-1:0] srl_cnt;
    logic [ADDR_WIDTH-1:0] raddr;
    logic                  push;
    logic                  pop;
    logic                  load;
    logic                  srl_empty;
    logic                  bypass;
    logic                  shift_en;

    assign count        = {1'b0, srl_cnt} + {{ADDR_WIDTH{1'b0}}, m_valid};
    assign s_ready      = (count != FULL_COUNT);
    assign almost_full  = (count >= AF_LEVEL);
    assign almost_empty = (count <= AE_LEVEL);

    assign push      = clk_en & s_valid & s_ready;
    assign pop       = clk_en & m_valid & m_ready;
    assign load      = ~m_valid | pop;
    assign srl_empty = (srl_cnt == '0);
    assign bypass    = load & srl_empty & push;
    assign raddr     = srl_cnt - CNT_ONE;
    assign shift_en  = push & ~bypass & ~flush & ~reset;

    // Storage has no reset and no write decode so it can map onto LUT shift registers.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            for (int i = DEPTH - 2; i > 0; i--) begin
                mem[i] <= mem[i-1];
            end
            mem[0] <= s_data;
        end
    end

    // Output register refills from the oldest stored word, or straight from s_data when
    // the shift array is empty; a simultaneous push keeps srl_cnt unchanged on a refill.
    always_ff @(posedge clk) begin
        if (reset) begin
            srl_cnt <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (clk_en) begin
            if (flush) begin
                srl_cnt <= '0;
                m_valid <= 1'b0;
            end else if (load) begin
                if (!srl_empty) begin
                    m_data  <= mem[raddr];
                    m_valid <= 1'b1;
                    if (!push) begin
                        srl_cnt <= srl_cnt - CNT_ONE;
                    end
                end else if (push) begin
                    m_data  <= s_data;
                    m_valid <= 1'b1;
                end else begin
                    m_valid <= 1'b0;
                end
            end else if (push) begin
                srl_cnt <= srl_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_m_axi_srl_fifo.sv
// Self-checking bench for m_axi_srl_fifo: directed steps plus random streaming,
// compared every cycle against a queue-based reference FIFO.
module tb_m_axi_srl_fifo;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 6;
    localparam int DEPTH      = 63;
    localparam int AF_MARGIN  = 4;
    localparam int AE_MARGIN  = 2;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  clk_en = 1'b0;
    logic                  flush = 1'b0;
    logic                  s_valid = 1'b0;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data = '0;
    logic                  m_valid;
    logic                  m_ready = 1'b0;
    logic [DATA_WIDTH-1:0] m_data;
    logic [ADDR_WIDTH:0]   count;
    logic                  almost_full;
    logic                  almost_empty;

    logic [DATA_WIDTH-1:0] ref_q [$];
    logic [DATA_WIDTH-1:0] junk;
    int tests = 0;
    int fails = 0;

    m_axi_srl_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH),
        .AF_MARGIN (AF_MARGIN),
        .AE_MARGIN (AE_MARGIN)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_en      (clk_en),
        .flush       (flush),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .count       (count),
        .almost_full (almost_full),
        .almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // Every visible output follows from the reference queue's occupancy and head.
    task automatic checkOutput(input string tag);
        int n;
        n = ref_q.size();
        compare({tag, ":count"}, 64'(count), 64'(n));
        compare({tag, ":s_ready"}, 64'(s_ready), 64'(n != DEPTH));
        compare({tag, ":m_valid"}, 64'(m_valid), 64'(n > 0));
        if (n > 0) compare({tag, ":m_data"}, 64'(m_data), 64'(ref_q[0]));
        compare({tag, ":almost_full"}, 64'(almost_full), 64'(n >= DEPTH - AF_MARGIN));
        compare({tag, ":almost_empty"}, 64'(almost_empty), 64'(n <= AE_MARGIN));
    endtask

    task automatic applyStimulus(input logic sv, input logic [DATA_WIDTH-1:0] sd,
                                 input logic mr, input logic ce, input logic fl,
                                 input string tag);
        bit do_push;
        bit do_pop;
        int n;
        @(negedge clk);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        clk_en  = ce;
        flush   = fl;
        n       = ref_q.size();
        do_push = ce && sv && (n != DEPTH);
        do_pop  = ce && mr && (n > 0);
        @(posedge clk);
        if (ce) begin
            if (fl) begin
                ref_q.delete();
            end else begin
                if (do_pop) junk = ref_q.pop_front();
                if (do_push) ref_q.push_back(sd);
            end
        end
        #1 checkOutput(tag);
    endtask

    task automatic applyReset(input string tag);
        @(negedge clk);
        reset   = 1'b1;
        clk_en  = 1'b0;
        flush   = 1'b1;
        s_valid = 1'b1;
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        ref_q.delete();
        checkOutput(tag);
        compare({tag, ":m_data_zero"}, 64'(m_data), 64'h0);
        @(negedge clk);
        reset   = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
    endtask

    initial begin
        // Reset state, then three pushes with the consumer stalled.
        applyReset("reset0");
        applyStimulus(1, 32'h11, 0, 1, 0, "push11");
        compare("bypass_latency", 64'(m_data), 64'h11);
        applyStimulus(1, 32'h22, 0, 1, 0, "push22");
        applyStimulus(1, 32'h33, 0, 1, 0, "push33");
        compare("ae_off_at_3", 64'(almost_empty), 64'h0);

        // Fill to DEPTH, push+pop while full, then drain in order.
        applyReset("reset_fill");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 32'(i), 0, 1, 0, "fill");
        compare("full_s_ready", 64'(s_ready), 64'h0);
        applyStimulus(1, 32'hFF, 1, 1, 0, "full_pushpop");
        compare("after_full_count", 64'(count), 64'(DEPTH - 1));
        while (ref_q.size() > 0) applyStimulus(0, 32'h0, 1, 1, 0, "drain");

        // Sustained push+pop at occupancy 5.
        applyReset("reset_stream");
        for (int i = 0; i < 5; i++) applyStimulus(1, 32'(i), 0, 1, 0, "occ5_fill");
        for (int i = 0; i < 100; i++) applyStimulus(1, 32'(100 + i), 1, 1, 0, "occ5_stream");
        compare("occ5_count", 64'(count), 64'd5);

        // Flush with a concurrent push, then a fresh word must come out first.
        applyReset("reset_flush");
        for (int i = 0; i < 10; i++) applyStimulus(1, 32'(i + 1), 0, 1, 0, "occ10_fill");
        applyStimulus(1, 32'hAA, 0, 1, 1, "flush_push");
        applyStimulus(1, 32'hBB, 0, 1, 0, "after_flush");
        compare("flush_first_word", 64'(m_data), 64'hBB);

        // Random streaming with a 3-cycle clk_en gap and occasional flushes.
        for (int i = 0; i < 300; i++) begin
            logic ce;
            logic fl;
            ce = (i >= 100 && i <= 102) ? 1'b0 : ($urandom_range(0, 9) != 0);
            fl = ($urandom_range(0, 149) == 0);
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                          ce, fl, "random");
        end

        // Reset mid-burst, then new data only.
        for (int i = 0; i < 8; i++) applyStimulus(1, $urandom, 0, 1, 0, "preburst");
        applyReset("reset_mid");
        applyStimulus(1, 32'hC0DE, 0, 1, 0, "post_reset");
        compare("post_reset_word", 64'(m_data), 64'hC0DE);
        while (ref_q.size() > 0) applyStimulus(0, 32'h0, 1, 1, 0, "final_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
